// File: rtl/bus_decode_pkg.sv
// Shared constants, watchdog state encoding and the address-decode helper
// for the 68030 board bus_decode block.
package bus_decode_pkg;

    localparam logic [3:0]  RAM_TOP4     = 4'h0;
    localparam logic [11:0] ROM_HI12     = 12'hFFF;
    localparam logic [11:0] IO_HI12      = 12'hFFE;
    localparam logic [2:0]  FC_CPU_SPACE = 3'b111;
    localparam logic [3:0]  IACK_TYPE    = 4'b1111;

    localparam logic [1:0] WD_IDLE  = 2'd0;
    localparam logic [1:0] WD_COUNT = 2'd1;
    localparam logic [1:0] WD_FAULT = 2'd2;
    localparam logic [1:0] WD_DONE  = 2'd3;

    typedef struct packed {
        logic ram;
        logic rom;
        logic io;
        logic rom_native;
        logic iack;
    } dec_t;

    // Active-high decode result; CPU space never selects memory or I/O.
    function automatic dec_t decode_addr(input logic       nas,
                                         input logic [2:0] fc,
                                         input logic       rnw,
                                         input logic [11:0] hi12,
                                         input logic [3:0] type4,
                                         input logic       overlay);
        dec_t d;
        d = '0;
        if (!nas) begin
            if (fc == FC_CPU_SPACE) begin
                d.iack = (type4 == IACK_TYPE);
            end else if (hi12[11:8] == RAM_TOP4) begin
                if (overlay && rnw) d.rom = 1'b1;
                else                d.ram = 1'b1;
            end else if (hi12 == ROM_HI12) begin
                d.rom        = 1'b1;
                d.rom_native = 1'b1;
            end else if (hi12 == IO_HI12) begin
                d.io = 1'b1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bus_decode_if.sv
// CPU-side bus bundle for bus_decode: the CPU drives the master side,
// the decoder sits on the slave side.
interface bus_decode_if;
    logic        nAS;
    logic        RnW;
    logic [2:0]  FC;
    logic [31:0] ADDR;
    logic [1:0]  nDSACK;
    logic        nSTERM;
    logic        nRAMSEL;
    logic        nROMSEL;
    logic        nIOSEL;
    logic        nBERR;
    logic        nAVEC;
    logic        OVERLAY;

    modport master (
        output nAS, RnW, FC, ADDR, nDSACK, nSTERM,
        input  nRAMSEL, nROMSEL, nIOSEL, nBERR, nAVEC, OVERLAY
    );

    modport slave (
        input  nAS, RnW, FC, ADDR, nDSACK, nSTERM,
        output nRAMSEL, nROMSEL, nIOSEL, nBERR, nAVEC, OVERLAY
    );
endinterface

// File: rtl/bus_watchdog.sv
// Bus watchdog: counts cycles of an unterminated bus cycle and raises
// bus error once TIMEOUT_CYCLES have elapsed without termination.
module bus_watchdog
    import bus_decode_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 512,
    parameter int CNT_W          = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic as_i,
    input  logic as_rise_i,
    input  logic term_i,
    output logic berr_n_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             berr_n_q, berr_n_d;

    // AS negation outranks termination, which outranks timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        berr_n_d = berr_n_q;
        case (state_q)
            WD_IDLE: begin
                if (as_rise_i) begin
                    state_d = WD_COUNT;
                    cnt_d   = '0;
                end
            end
            WD_COUNT: begin
                if (!as_i) begin
                    state_d = WD_IDLE;
                end else if (term_i) begin
                    state_d = WD_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = WD_FAULT;
                    berr_n_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WD_FAULT: begin
                if (!as_i) begin
                    state_d  = WD_IDLE;
                    berr_n_d = 1'b1;
                end
            end
            default: begin
                if (!as_i) state_d = WD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= WD_IDLE;
            cnt_q    <= '0;
            berr_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            berr_n_q <= berr_n_d;
        end
    end

    assign berr_n_o = berr_n_q;

endmodule

// File: rtl/bus_decode.sv
// Address decode, boot-ROM overlay and bus supervision for the 68030 board.
// Define BUS_DECODE_AUTOVEC_EN to answer IACK cycles with nAVEC.
module bus_decode
    import bus_decode_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 512,
    parameter int CNT_W          = 10
) (
    input  logic         CLK,
    input  logic         RST,
    bus_decode_if.slave  bus
);

    logic as1_q, as_q, asp_q;
    logic term1_q, term_q;
    logic overlay_q, overlay_d;
    logic as_rise;
    logic avec_n;
    logic wd_term;
    logic berr_n;
    dec_t dec;

    assign dec = decode_addr(bus.nAS, bus.FC, bus.RnW, bus.ADDR[31:20],
                             bus.ADDR[19:16], overlay_q);
    assign as_rise = as_q & ~asp_q;

    // nAS and the termination lines are asynchronous to CLK.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            as1_q   <= 1'b0;
            as_q    <= 1'b0;
            asp_q   <= 1'b0;
            term1_q <= 1'b0;
            term_q  <= 1'b0;
        end else begin
            as1_q   <= ~bus.nAS;
            as_q    <= as1_q;
            asp_q   <= as_q;
            term1_q <= ~bus.nDSACK[0] | ~bus.nDSACK[1] | ~bus.nSTERM;
            term_q  <= term1_q;
        end
    end

    // The first native ROM access ends the overlay until the next reset.
    assign overlay_d = (as_rise && dec.rom_native) ? 1'b0 : overlay_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) overlay_q <= 1'b1;
        else     overlay_q <= overlay_d;
    end

`ifdef BUS_DECODE_AUTOVEC_EN
    logic avec_n_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                     avec_n_q <= 1'b1;
        else if (!as_q)              avec_n_q <= 1'b1;
        else if (as_rise && dec.iack) avec_n_q <= 1'b0;
    end

    assign avec_n  = avec_n_q;
    assign wd_term = term_q | ~avec_n_q;
`else
    assign avec_n  = 1'b1;
    assign wd_term = term_q;
`endif

    bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk_i     (CLK),
        .rst_i     (RST),
        .as_i      (as_q),
        .as_rise_i (as_rise),
        .term_i    (wd_term),
        .berr_n_o  (berr_n)
    );

    assign bus.nRAMSEL = ~dec.ram;
    assign bus.nROMSEL = ~dec.rom;
    assign bus.nIOSEL  = ~dec.io;
    assign bus.nBERR   = berr_n;
    assign bus.nAVEC   = avec_n;
    assign bus.OVERLAY = overlay_q;

    logic unused_bits;
    assign unused_bits = ^{bus.ADDR[15:0], dec.iack};

endmodule

// File: tb/tb_bus_decode.sv
// Self-checking bench for bus_decode with a short watchdog timeout; expected
// outputs come from an edge-timeline model of each CPU bus cycle.
module tb_bus_decode;
    import bus_decode_pkg::*;

    localparam int TO_CYC  = 16;
    localparam int TO_EDGE = TO_CYC + 3;   // 2 sync edges + ASrise edge, then TO_CYC counts
`ifdef BUS_DECODE_AUTOVEC_EN
    localparam bit AVEC = 1'b1;
`else
    localparam bit AVEC = 1'b0;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    bit   ovl_m;

    bus_decode_if bif ();

    bus_decode #(
        .TIMEOUT_CYCLES (TO_CYC),
        .CNT_W          (5)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    // Returns {ram, rom, io} active-high from the memory map.
    function automatic logic [2:0] ref_sel(input logic [31:0] a, input logic [2:0] fc,
                                           input logic rnw, input bit ovl);
        if (fc == 3'd7)            return 3'b000;
        if (a < 32'h1000_0000)     return (ovl && rnw) ? 3'b010 : 3'b100;
        if (a >= 32'hFFF0_0000)    return 3'b010;
        if (a >= 32'hFFE0_0000)    return 3'b001;
        return 3'b000;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".nRAMSEL"}, bif.nRAMSEL, 1'b1);
        check({tag, ".nROMSEL"}, bif.nROMSEL, 1'b1);
        check({tag, ".nIOSEL"},  bif.nIOSEL,  1'b1);
        check({tag, ".nBERR"},   bif.nBERR,   1'b1);
        check({tag, ".nAVEC"},   bif.nAVEC,   1'b1);
        check({tag, ".OVERLAY"}, bif.OVERLAY, ovl_m);
    endtask

    // One bus cycle: nAS falls after edge 0, termination asserted after edge t
    // (0 = none), nAS released after edge r. Called #1 after a rising edge.
    task automatic run_cycle(input string tag, input logic [31:0] addr, input logic [2:0] fc,
                             input logic rnw, input int t, input int r, input bit use_sterm);
        logic [2:0] sel;
        bit native, iack, fault, term_on;
        int term_edge;
        native    = (fc != 3'd7) && (addr >= 32'hFFF0_0000);
        iack      = (fc == 3'd7) && (addr[19:16] == 4'hF);
        term_on   = (t > 0) && (t < r);
        term_edge = term_on ? t + 3 : 1000;
        if (AVEC && iack && term_edge > 4) term_edge = 4;
        fault = (TO_EDGE < r + 3) && (TO_EDGE < term_edge);

        bif.ADDR = addr;
        bif.FC   = fc;
        bif.RnW  = rnw;
        bif.nAS  = 1'b0;
        for (int k = 1; k <= r + 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 3 && native) ovl_m = 1'b0;
            sel = (k <= r) ? ref_sel(addr, fc, rnw, ovl_m) : 3'b000;
            check({tag, ".nRAMSEL"}, bif.nRAMSEL, !sel[2]);
            check({tag, ".nROMSEL"}, bif.nROMSEL, !sel[1]);
            check({tag, ".nIOSEL"},  bif.nIOSEL,  !sel[0]);
            check({tag, ".OVERLAY"}, bif.OVERLAY, ovl_m);
            check({tag, ".nBERR"},   bif.nBERR,   !(fault && k >= TO_EDGE && k < r + 3));
            check({tag, ".nAVEC"},   bif.nAVEC,   !(AVEC && iack && k >= 3 && k < r + 3));
            if (term_on && k == t) begin
                if (use_sterm) bif.nSTERM = 1'b0;
                else           bif.nDSACK = 2'($urandom_range(0, 2));
            end
            if (k == r) begin
                bif.nAS    = 1'b1;
                bif.nDSACK = 2'b11;
                bif.nSTERM = 1'b1;
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  fc;
        int          t, r;
        vectors     = 0;
        miscompares = 0;
        ovl_m       = 1'b1;

        // Reset
        rst        = 1'b1;
        bif.nAS    = 1'b1;
        bif.RnW    = 1'b1;
        bif.FC     = 3'd0;
        bif.ADDR   = 32'h0;
        bif.nDSACK = 2'b11;
        bif.nSTERM = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("post_reset");

        // Directed cycles
        run_cycle("ovl_read",   32'h0000_0100, 3'b110, 1'b1, 4, 7, 1'b0);
        run_cycle("ovl_write",  32'h0000_0010, 3'b101, 1'b0, 3, 6, 1'b0);
        run_cycle("rom_native", 32'hFFF0_0000, 3'b110, 1'b1, 4, 8, 1'b0);
        run_cycle("ram_read",   32'h0000_0100, 3'b110, 1'b1, 4, 8, 1'b0);
        run_cycle("timeout",    32'h8000_0000, 3'b101, 1'b1, 0, 24, 1'b0);
        run_cycle("term_tie",   32'h8000_0000, 3'b101, 1'b1, TO_EDGE - 3, 24, 1'b0);
        run_cycle("as_tie",     32'h8000_0000, 3'b101, 1'b1, 0, TO_EDGE - 3, 1'b0);
        run_cycle("io_sterm",   32'hFFE0_1234, 3'b101, 1'b0, 2, 6, 1'b1);
        run_cycle("iack",       32'hFFFF_000F, 3'b111, 1'b1, 0, 24, 1'b0);

        // Asynchronous reset while nBERR is held
        bif.ADDR = 32'h8000_0000;
        bif.FC   = 3'b101;
        bif.nAS  = 1'b0;
        repeat (TO_EDGE + 2) @(posedge clk);
        #1;
        check("rst_fault.nBERR", bif.nBERR, 1'b0);
        check("rst_fault.OVERLAY", bif.OVERLAY, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        ovl_m = 1'b1;
        check("rst_async.nBERR",   bif.nBERR,   1'b1);
        check("rst_async.OVERLAY", bif.OVERLAY, 1'b1);
        bif.nAS = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_idle("rst_recover");

        // Randomized cycles
        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            fc = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: a[31:28] = 4'h0;
                1: a[31:20] = 12'hFFF;
                2: a[31:20] = 12'hFFE;
                3: begin a[19:16] = 4'hF; fc = 3'd7; end
                default: ;
            endcase
            t = $urandom_range(0, 22);
            r = $urandom_range(3, 24);
            run_cycle("random", a, fc, 1'($urandom_range(0, 1)), t, r, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
